// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from uart_rx_ctrl to its consumer: valid/ready handshake with the head-of-FIFO byte.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data_out;
  logic                 m_valid_out;
  logic                 m_ready_in;

  modport master (output m_data_out, output m_valid_out, input m_ready_in);
  modport slave  (input m_data_out, input m_valid_out, output m_ready_in);
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller behind uart_rx: edge-detects the ready pulse, buffers bytes, flags overrun.
// Optional idle-line timeout pulse is built only when UART_RX_CTRL_TIMEOUT_EN is defined.
//
// state  | meaning
// S_OFF  | reception disabled; byte events ignored, pops still allowed
// S_WAIT | enabled, idle timer stopped
// S_GAP  | enabled, counting idle cycles since the last push (timeout build only)
module uart_rx_ctrl #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic                        clk_in,
  input  logic                        nrst_in,
  input  logic                        en_in,
  input  logic                        clr_in,
  input  logic                        rx_rdy_in,
  input  logic [DATA_BITS-1:0]        rx_data_in,
  uart_rx_ctrl_if.master              m_if,
  output logic [$clog2(FIFO_DEPTH):0] level_out,
  output logic                        overrun_out,
  output logic                        timeout_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_rx_ctrl: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("uart_rx_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_OFF,
    S_WAIT
`ifdef UART_RX_CTRL_TIMEOUT_EN
    , S_GAP
`endif
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

  logic push, pop, full, wr_ok;

  assign push  = rx_rdy_in & ~rx_rdy_q & en_in;
  assign pop   = (level_q != '0) & m_if.m_ready_in;
  assign full  = (level_q == FULL_LVL);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_ok = push & (~full | pop);

  always_comb begin
    rx_rdy_d  = rx_rdy_in;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    mem_d     = mem_q;
    if (clr_in) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q] = rx_data_in;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(wr_ok) - LVL_W'(pop);
      if (push && full && !pop) begin
        overrun_d = 1'b1;
      end
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    if (clr_in) begin
      state_d = en_in ? S_WAIT : S_OFF;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      cnt_d = '0;
`endif
    end else if (!en_in) begin
      state_d = S_OFF;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      cnt_d = '0;
`endif
    end else begin
      case (state_q)
        S_OFF: state_d = S_WAIT;
        S_WAIT: begin
`ifdef UART_RX_CTRL_TIMEOUT_EN
          if (push) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
`endif
        end
`ifdef UART_RX_CTRL_TIMEOUT_EN
        S_GAP: begin
          if (push) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_WAIT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q   <= S_OFF;
      rx_rdy_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`ifdef UART_RX_CTRL_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_rdy_q  <= rx_rdy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      mem_q     <= mem_d;
`ifdef UART_RX_CTRL_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign m_if.m_data_out  = mem_q[rd_ptr_q];
  assign m_if.m_valid_out = (level_q != '0);
  assign level_out        = level_q;
  assign overrun_out      = overrun_q;
`ifdef UART_RX_CTRL_TIMEOUT_EN
  assign timeout_out = timeout_q;
`else
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a behavioural model keeps a queue of expected bytes and is checked every cycle.
module tb_uart_rx_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 80;

  logic          clk_in = 1'b0;
  logic          nrst_in;
  logic          en_in;
  logic          clr_in;
  logic          rx_rdy_in;
  logic [DW-1:0] rx_data_in;
  logic [2:0]    level_out;
  logic          overrun_out;
  logic          timeout_out;

  uart_rx_ctrl_if #(.DATA_BITS(DW)) m_if ();

  uart_rx_ctrl #(
    .DATA_BITS      (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in      (clk_in),
    .nrst_in     (nrst_in),
    .en_in       (en_in),
    .clr_in      (clr_in),
    .rx_rdy_in   (rx_rdy_in),
    .rx_data_in  (rx_data_in),
    .m_if        (m_if.master),
    .level_out   (level_out),
    .overrun_out (overrun_out),
    .timeout_out (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] exp_q[$];
  bit exp_ovr     = 1'b0;
  bit exp_to      = 1'b0;
  bit rdy_prev    = 1'b0;
  bit tmr_active  = 1'b0;
  int since       = 0;
  int cyc         = 0;
  int pulse_cnt   = 0;
  int first_pulse = -1;
  int c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state();
    check("level", 32'(level_out), 32'(exp_q.size()));
    check("valid", 32'(m_if.m_valid_out), 32'(exp_q.size() != 0));
    check("overrun", 32'(overrun_out), 32'(exp_ovr));
    check("timeout", 32'(timeout_out), 32'(exp_to));
    if (exp_q.size() != 0) check("head_data", 32'(m_if.m_data_out), 32'(exp_q[0]));
  endtask

  // One clock: predict from current inputs, advance, compare.
  task automatic step();
    bit evt, push, pop;
    evt  = rx_rdy_in && !rdy_prev;
    push = evt && en_in;
    pop  = (exp_q.size() != 0) && m_if.m_ready_in;
    if (pop) check("pop_data", 32'(m_if.m_data_out), 32'(exp_q[0]));
    if (clr_in) begin
      exp_q.delete();
      exp_ovr = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(rx_data_in);
        else exp_ovr = 1'b1;
      end
    end
    if (clr_in || !en_in) tmr_active = 1'b0;
    else if (push) begin
      tmr_active = 1'b1;
      since      = 0;
    end
    rdy_prev = rx_rdy_in;
    @(posedge clk_in);
    #1;
    cyc++;
    exp_to = 1'b0;
    if (tmr_active) begin
      since++;
      if (since == TO + 1) begin
        tmr_active = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
        exp_to = 1'b1;
`endif
      end
    end
    check_state();
    if (timeout_out === 1'b1) begin
      pulse_cnt++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input int hold);
    rx_data_in = d;
    rx_rdy_in  = 1'b1;
    repeat (hold) step();
    rx_rdy_in = 1'b0;
    step();
  endtask

  initial begin
    nrst_in        = 1'b1;
    en_in          = 1'b0;
    clr_in         = 1'b0;
    rx_rdy_in      = 1'b0;
    rx_data_in     = '0;
    m_if.m_ready_in = 1'b0;
    #3 nrst_in = 1'b0;
    #1;
    check("rst_level", 32'(level_out), 0);
    check("rst_valid", 32'(m_if.m_valid_out), 0);
    check("rst_overrun", 32'(overrun_out), 0);
    check("rst_timeout", 32'(timeout_out), 0);
    check("rst_data", 32'(m_if.m_data_out), 0);
    @(posedge clk_in);
    #1 nrst_in = 1'b1;

    // Single byte held high for three cycles gives one entry.
    en_in = 1'b1;
    step();
    step();
    send(8'hA5, 3);
    step();
    check("single_level", 32'(level_out), 1);
    check("single_data", 32'(m_if.m_data_out), 32'h00A5);
    m_if.m_ready_in = 1'b1;
    step();
    m_if.m_ready_in = 1'b0;

    // Overrun on the fifth byte, drain, then flush.
    for (int i = 1; i <= 5; i++) send(DW'(i), 1);
    check("ovr_level", 32'(level_out), 4);
    check("ovr_flag", 32'(overrun_out), 1);
    m_if.m_ready_in = 1'b1;
    repeat (5) step();
    m_if.m_ready_in = 1'b0;
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    check("ovr_cleared", 32'(overrun_out), 0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 4; i++) send(DW'(8'h10 + i), 1);
    rx_data_in      = 8'h55;
    rx_rdy_in       = 1'b1;
    m_if.m_ready_in = 1'b1;
    step();
    check("fullpop_level", 32'(level_out), 4);
    check("fullpop_ovr", 32'(overrun_out), 0);
    rx_rdy_in = 1'b0;
    repeat (5) step();
    m_if.m_ready_in = 1'b0;

    // Push while empty with ready already high, then clear racing a push.
    m_if.m_ready_in = 1'b1;
    send(8'h33, 1);
    step();
    m_if.m_ready_in = 1'b0;
    send(8'h34, 1);
    rx_data_in = 8'h35;
    rx_rdy_in  = 1'b1;
    clr_in     = 1'b1;
    step();
    clr_in    = 1'b0;
    rx_rdy_in = 1'b0;
    step();

    // Enable gating, and draining while disabled.
    en_in = 1'b0;
    send(8'h11, 1);
    check("gated_level", 32'(level_out), 0);
    en_in = 1'b1;
    step();
    send(8'h21, 1);
    send(8'h22, 1);
    en_in = 1'b0;
    step();
    m_if.m_ready_in = 1'b1;
    repeat (3) step();
    m_if.m_ready_in = 1'b0;
    check("off_drained", 32'(m_if.m_valid_out), 0);

    // Idle timeout: pushes at relative cycles 0 and 50.
    en_in = 1'b1;
    repeat (2) step();
    pulse_cnt   = 0;
    first_pulse = -1;
    c0          = cyc;
    m_if.m_ready_in = 1'b1;
    send(8'h40, 1);
    while (cyc < c0 + 50) step();
    send(8'h41, 1);
    repeat (100) step();
    m_if.m_ready_in = 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    check("to_pulses", 32'(pulse_cnt), 1);
    check("to_cycle", 32'(first_pulse - c0), 131);
`else
    check("to_pulses", 32'(pulse_cnt), 0);
`endif

    // Asynchronous reset with bytes queued and the timer running.
    send(8'h61, 1);
    send(8'h62, 1);
    send(8'h63, 1);
    repeat (3) step();
    #2 nrst_in = 1'b0;
    #1;
    check("arst_level", 32'(level_out), 0);
    check("arst_valid", 32'(m_if.m_valid_out), 0);
    check("arst_overrun", 32'(overrun_out), 0);
    check("arst_timeout", 32'(timeout_out), 0);
    check("arst_data", 32'(m_if.m_data_out), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
